// File: rtl/regfile_port_sched_if.sv
// Bundle of the instruction, operand, register-file and write-back signals
// exchanged between the operand sequencer and its surroundings.
// master: upstream decode / execute / write-back / register-file side.
// slave : the sequencer (regfile_port_sched).
interface regfile_port_sched_if #(
  parameter int DATA_W = 32
);
  // Instruction intake
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic              need_rn;
  logic              need_rm;
  logic              need_rs;
  logic              wb_en;
  logic              dest_is_pc;

  // Register-file read ports (asynchronous read data)
  logic [3:0]        rf_ra0;
  logic [3:0]        rf_ra1;
  logic [DATA_W-1:0] rf_rd0;
  logic [DATA_W-1:0] rf_rd1;

  // Operand hand-off to execute
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_rn;
  logic [DATA_W-1:0] op_rm;
  logic [DATA_W-1:0] op_rs;
  logic [3:0]        op_dest;

  // Write-back requesters
  logic              mem_wb_valid;
  logic              mem_wb_ready;
  logic [3:0]        mem_wb_addr;
  logic [DATA_W-1:0] mem_wb_data;
  logic              alu_wb_valid;
  logic              alu_wb_ready;
  logic [3:0]        alu_wb_addr;
  logic [DATA_W-1:0] alu_wb_data;

  // Register-file write port
  logic              rf_we;
  logic [3:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;

  modport master (
    output instr_valid, instr, need_rn, need_rm, need_rs, wb_en, dest_is_pc,
    output rf_rd0, rf_rd1, op_ready,
    output mem_wb_valid, mem_wb_addr, mem_wb_data,
    output alu_wb_valid, alu_wb_addr, alu_wb_data,
    input  instr_ready, rf_ra0, rf_ra1,
    input  op_valid, op_rn, op_rm, op_rs, op_dest,
    input  mem_wb_ready, alu_wb_ready, rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  instr_valid, instr, need_rn, need_rm, need_rs, wb_en, dest_is_pc,
    input  rf_rd0, rf_rd1, op_ready,
    input  mem_wb_valid, mem_wb_addr, mem_wb_data,
    input  alu_wb_valid, alu_wb_addr, alu_wb_data,
    output instr_ready, rf_ra0, rf_ra1,
    output op_valid, op_rn, op_rm, op_rs, op_dest,
    output mem_wb_ready, alu_wb_ready, rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/regfile_port_sched.sv
// Operand sequencer and write-port arbiter for a 16x32 register file with
// two asynchronous read ports and one write port. One instruction at a time
// is read out (Rn/Rm in one cycle, Rs in a second), stalled on a
// pending-write scoreboard, and handed to execute with valid/ready.
// Write-back is arbitrated combinationally, memory before ALU.
module regfile_port_sched #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  regfile_port_sched_if.slave   io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ1 = 2'd1,
    ST_READ2 = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  // FSM state and registered handshake outputs
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_instr_ready;
  logic              r_op_valid;

  // Captured instruction fields and flags
  logic [3:0]        r_rn;
  logic [3:0]        r_rm;
  logic [3:0]        r_rs;
  logic [3:0]        r_dest;
  logic              r_need_rn;
  logic              r_need_rm;
  logic              r_need_rs;
  logic              r_wb_en;

  // Latched operands presented to execute
  logic [DATA_W-1:0] r_op_rn;
  logic [DATA_W-1:0] r_op_rm;
  logic [DATA_W-1:0] r_op_rs;
  logic [3:0]        r_op_dest;

  // Pending-write scoreboard, one bit per register
  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_pending_nxt;
  logic [NREG-1:0]   w_clr_mask;
  logic [NREG-1:0]   w_set_mask;

  // FSM strobes
  logic              w_accept;
  logic              w_latch_r1;
  logic              w_latch_r2;
  logic              w_issue_hs;
  logic              w_hazard_r1;
  logic              w_hazard_r2;

  // Read-address and write-port combinational signals
  logic [3:0]        w_ra0;
  logic [3:0]        w_ra1;
  logic              w_mem_ready;
  logic              w_alu_ready;
  logic              w_we;
  logic [3:0]        w_wa;
  logic [DATA_W-1:0] w_wd;

  // Resolved destination of the instruction being offered
  logic [3:0]        w_dest_in;

  // Encoding bits the sequencer has no use for
  logic              w_unused_instr_bits;

  assign w_unused_instr_bits = ^{io_bus.instr[31:20], io_bus.instr[7:4]};

  assign w_dest_in = io_bus.dest_is_pc ? 4'd15 : io_bus.instr[15:12];

  // RAW on either needed first-cycle operand, or WAW on the destination.
  assign w_hazard_r1 = (r_need_rn & r_pending[r_rn]) |
                       (r_need_rm & r_pending[r_rm]) |
                       (r_wb_en   & r_pending[r_dest]);

  assign w_hazard_r2 = r_pending[r_rs];

  // Next-state logic and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_latch_r1  = 1'b0;
    w_latch_r2  = 1'b0;
    w_issue_hs  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.instr_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_READ1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ1: begin
        if (w_hazard_r1) begin
          w_state_nxt = ST_READ1;
        end else begin
          w_latch_r1  = 1'b1;
          w_state_nxt = r_need_rs ? ST_READ2 : ST_ISSUE;
        end
      end
      ST_READ2: begin
        if (w_hazard_r2) begin
          w_state_nxt = ST_READ2;
        end else begin
          w_latch_r2  = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (io_bus.op_ready) begin
          w_issue_hs  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read-port address steering; idle/issue park both ports at R0
  always_comb begin
    w_ra0 = 4'd0;
    w_ra1 = 4'd0;
    case (r_state)
      ST_READ1: begin
        w_ra0 = r_rn;
        w_ra1 = r_rm;
      end
      ST_READ2: begin
        w_ra0 = r_rs;
        w_ra1 = r_rs;
      end
      default: begin
        w_ra0 = 4'd0;
        w_ra1 = 4'd0;
      end
    endcase
  end

  // Fixed-priority write-port arbitration, memory ahead of ALU
  always_comb begin
    w_mem_ready = 1'b0;
    w_alu_ready = 1'b0;
    w_we        = 1'b0;
    w_wa        = 4'd0;
    w_wd        = {DATA_W{1'b0}};
    if (io_bus.mem_wb_valid) begin
      w_mem_ready = 1'b1;
      w_we        = 1'b1;
      w_wa        = io_bus.mem_wb_addr;
      w_wd        = io_bus.mem_wb_data;
    end else if (io_bus.alu_wb_valid) begin
      w_alu_ready = 1'b1;
      w_we        = 1'b1;
      w_wa        = io_bus.alu_wb_addr;
      w_wd        = io_bus.alu_wb_data;
    end else begin
      w_we        = 1'b0;
    end
  end

  // Scoreboard update: clear on the write edge, set on issue (set wins)
  always_comb begin
    w_clr_mask    = w_we ? ({{(NREG-1){1'b0}}, 1'b1} << w_wa) : {NREG{1'b0}};
    w_set_mask    = (w_issue_hs & r_wb_en) ? ({{(NREG-1){1'b0}}, 1'b1} << r_dest)
                                           : {NREG{1'b0}};
    w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
  end

  // State register, registered handshake flags and scoreboard
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_instr_ready <= 1'b1;
      r_op_valid    <= 1'b0;
      r_pending     <= {NREG{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_instr_ready <= (w_state_nxt == ST_IDLE);
      r_op_valid    <= (w_state_nxt == ST_ISSUE);
      r_pending     <= w_pending_nxt;
    end
  end

  // Capture the offered instruction's fields on acceptance
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rn      <= 4'd0;
      r_rm      <= 4'd0;
      r_rs      <= 4'd0;
      r_dest    <= 4'd0;
      r_need_rn <= 1'b0;
      r_need_rm <= 1'b0;
      r_need_rs <= 1'b0;
      r_wb_en   <= 1'b0;
    end else if (w_accept) begin
      r_rn      <= io_bus.instr[19:16];
      r_rm      <= io_bus.instr[3:0];
      r_rs      <= io_bus.instr[11:8];
      r_dest    <= w_dest_in;
      r_need_rn <= io_bus.need_rn;
      r_need_rm <= io_bus.need_rm;
      r_need_rs <= io_bus.need_rs;
      r_wb_en   <= io_bus.wb_en;
    end
  end

  // Operand latches; they only move in READ1/READ2, so they hold in ISSUE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op_rn   <= {DATA_W{1'b0}};
      r_op_rm   <= {DATA_W{1'b0}};
      r_op_rs   <= {DATA_W{1'b0}};
      r_op_dest <= 4'd0;
    end else if (w_latch_r1) begin
      r_op_rn   <= io_bus.rf_rd0;
      r_op_rm   <= io_bus.rf_rd1;
      r_op_dest <= r_dest;
      // Without an Rs operand the shift operand is defined as zero.
      r_op_rs   <= r_need_rs ? r_op_rs : {DATA_W{1'b0}};
    end else if (w_latch_r2) begin
      r_op_rs   <= io_bus.rf_rd0;
    end
  end

  assign io_bus.instr_ready  = r_instr_ready;
  assign io_bus.op_valid     = r_op_valid;
  assign io_bus.op_rn        = r_op_rn;
  assign io_bus.op_rm        = r_op_rm;
  assign io_bus.op_rs        = r_op_rs;
  assign io_bus.op_dest      = r_op_dest;
  assign io_bus.rf_ra0       = w_ra0;
  assign io_bus.rf_ra1       = w_ra1;
  assign io_bus.mem_wb_ready = w_mem_ready;
  assign io_bus.alu_wb_ready = w_alu_ready;
  assign io_bus.rf_we        = w_we;
  assign io_bus.rf_wa        = w_wa;
  assign io_bus.rf_wd        = w_wd;

endmodule

// File: doc/regfile_port_sched.md
# regfile_port_sched

Sequencer and arbiter for the processor's 16×32 register file: two asynchronous read ports and one write port. It accepts one decoded instruction at a time and reads its Rn/Rm/Rs operands over the two read ports, taking one or two cycles. It stalls on a 16-bit pending-write scoreboard, hands the operands to the execute stage with a valid/ready handshake, and arbitrates the single write port between ALU and data-memory write-back.

## Interface
Parameters
- DATA_W, 32, register width
- NREG, 16, register count (address width fixed at 4)

Ports
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  decoded instruction offered
- instr_ready  out  1  sequencer accepts instruction
- instr  in  32  encoding: Rn=[19:16], Rd=[15:12], Rs=[11:8], Rm=[3:0]
- need_rn, need_rm, need_rs  in  1 each  operand used
- wb_en  in  1  instruction writes a register
- dest_is_pc  in  1  destination is R15 instead of Rd
- rf_ra0, rf_ra1  out  4 each  read addresses
- rf_rd0, rf_rd1  in  DATA_W each  combinational read data
- op_valid  out  1  operands ready for execute
- op_ready  in  1  execute accepts
- op_rn, op_rm, op_rs  out  DATA_W each  latched operands
- op_dest  out  4  resolved destination address
- mem_wb_valid, alu_wb_valid  in  1 each  write-back request
- mem_wb_addr, alu_wb_addr  in  4 each
- mem_wb_data, alu_wb_data  in  DATA_W each
- mem_wb_ready, alu_wb_ready  out  1 each  request granted this cycle
- rf_we  out  1; rf_wa  out  4; rf_wd  out  DATA_W  write port

## Operation
- FSM states: IDLE, READ1, READ2, ISSUE.
- IDLE: instr_ready=1.
  - On instr_valid, capture the fields and flags, and go to READ1.
  - dest = dest_is_pc ? 15 : Rd.
- READ1: rf_ra0=Rn, rf_ra1=Rm.
  - Hazard exists if any of these pending bits is set: need_rn and Rn; need_rm and Rm; wb_en and dest (WAW).
  - Hazard: stay in READ1.
  - No hazard: latch rf_rd0→op_rn and rf_rd1→op_rm (unneeded operands latch whatever is read). Then go to READ2 if need_rs, else to ISSUE.
- READ2: rf_ra0=Rs, rf_ra1=Rs.
  - Stall while pending[Rs] is set.
  - Otherwise latch rf_rd0→op_rs and go to ISSUE.
- When need_rs=0, op_rs=0.
- ISSUE: op_valid=1 and outputs are held stable.
  - On op_ready: set pending[dest] if wb_en, then go to IDLE.
- Outside ISSUE, op_valid=0.
- Scoreboard: pending[15:0].
  - Cleared at the rf_we edge for rf_wa.
  - Set at the issue handshake.
  - Same-register set and clear in the same cycle cannot occur because of the WAW check. Set wins regardless.
- Write-back arbitration is fixed priority, memory over ALU.
  - mem_wb_ready = mem_wb_valid.
  - alu_wb_ready = alu_wb_valid & ~mem_wb_valid.
  - rf_we = mem_wb_valid | alu_wb_valid; rf_wa and rf_wd come from the granted source.
  - All combinational.
  - An ungranted requester holds its request.
- No forwarding: a read waits at least one cycle after its producer's write edge.
- Write-back to an address whose pending bit is clear is legal: the write is performed and the bit stays 0.

## Timing
- Reset (synchronous, active-high) values:
  - state=IDLE, pending=0.
  - op_rn, op_rm, op_rs = 0; op_dest=0; op_valid=0.
  - instr_ready=1 after the reset cycle.
  - Read addresses default to 0 in IDLE.
- rst asserted mid-operation aborts any in-flight instruction and clears the scoreboard. Write-backs presented during a reset cycle are still forwarded to rf_we combinationally; the scoreboard ignores them.
- Latency from instr_valid&instr_ready to op_valid:
  - 2 cycles without Rs (IDLE→READ1→ISSUE).
  - 3 cycles with Rs.
  - Plus one cycle per stall cycle.
- Throughput: one instruction per 3 cycles, or 4 with Rs, when op_ready=1.
- The write-back path has zero latency. A pending bit clears at the same edge the register file writes, so a stalled READ1/READ2 proceeds on the next cycle.
- op_valid stays asserted with constant outputs until op_ready.

## Test plan
- Reset, then instr with Rn=2, Rm=3, need_rs=0, wb_en=1, Rd=4, op_ready=1 → op_valid 2 cycles after accept, op_rn=R2, op_rm=R3, op_dest=4, pending=0x0010.
- Instr with need_rs=1, Rs=5 (R5=0xA5A5A5A5) → one extra cycle in READ2, op_rs=0xA5A5A5A5.
- RAW: pending[3] set, new instr needs Rm=3 → stays in READ1. Then alu_wb R3=0x1234 → next cycle op_rm=0x1234 and pending[3]=0.
- WAW: pending[15] set, instr with dest_is_pc=1 → stalls until a write to R15 occurs. On issue, op_dest=15 and pending[15]=1.
- mem_wb and alu_wb asserted in the same cycle (R1=0x11, R2=0x22) → cycle 1 writes R1 with mem_wb_ready=1 and alu_wb_ready=0; cycle 2 writes R2.
- op_ready held 0 for 5 cycles in ISSUE → op_valid stays 1 with stable outputs and instr_ready=0. rst asserted mid-READ2 → IDLE, pending=0, op_valid=0 on the next cycle.
